// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: connects the EX/MEM stage to a word-only data memory. Handles byte, halfword and word loads and stores.
// Define MEM_SUBWORD_EN to build sub-word support: stores become read-merge-write through the MERGE state.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_pos,
    output logic [31:0]       mem_data,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned DATA_W  = 32;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    logic [ADDR_W-1:0] word_pos;
    logic              aligned;
    logic              in_idle;
    logic              load_go;
    logic              reject_go;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_ext;

    assign word_pos = {req_addr[ADDR_W-1:2], 2'b00};

    // Legality of the request's size/offset combination
    always_comb begin
        aligned = 1'b0;
`ifdef MEM_SUBWORD_EN
        case (req_size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~req_addr[0];
            SZ_WORD: aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
`else
        aligned = (req_size == SZ_WORD) && (req_addr[1:0] == 2'b00);
`endif
    end

    // Big-endian lane extraction and sign/zero extension of the load word
    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (req_addr[1:0])
            2'd0:    lane_byte = mem_rdata[31:24];
            2'd1:    lane_byte = mem_rdata[23:16];
            2'd2:    lane_byte = mem_rdata[15:8];
            default: lane_byte = mem_rdata[7:0];
        endcase
        lane_half = req_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (req_size)
            SZ_BYTE: load_ext = {{24{req_signed & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_ext = {{16{req_signed & lane_half[15]}}, lane_half};
            default: load_ext = mem_rdata;
        endcase
    end

`ifdef MEM_SUBWORD_EN
    typedef enum logic {IDLE, MERGE} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] merge_d;
    logic [ADDR_W-1:0] hold_q;
    logic [ADDR_W-1:0] hold_d;
    logic [DATA_W-1:0] merged;

    // Current memory word with the store lane(s) replaced
    always_comb begin
        merged = mem_rdata;
        if (req_size == SZ_HALF) begin
            if (req_addr[1]) merged[15:0]  = req_wdata[15:0];
            else             merged[31:16] = req_wdata[15:0];
        end else begin
            case (req_addr[1:0])
                2'd0:    merged[31:24] = req_wdata[7:0];
                2'd1:    merged[23:16] = req_wdata[7:0];
                2'd2:    merged[15:8]  = req_wdata[7:0];
                default: merged[7:0]   = req_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            merge_q <= '0;
            hold_q  <= '0;
        end else begin
            state   <= next_state;
            merge_q <= merge_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        next_state = state;
        merge_d    = merge_q;
        hold_d     = hold_q;
        in_idle    = 1'b0;
        stall      = 1'b0;
        mem_wr     = 1'b0;
        mem_pos    = word_pos;
        mem_data   = req_wdata;
        case (state)
            IDLE: begin
                in_idle = 1'b1;
                if (req_valid && aligned && req_wr) begin
                    if (req_size == SZ_WORD) begin
                        mem_wr = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        merge_d    = merged;
                        hold_d     = word_pos;
                        next_state = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_pos    = hold_q;
                mem_data   = merge_q;
                mem_wr     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Reset drops any pending merge write
        if (rst) begin
            stall      = 1'b0;
            mem_wr     = 1'b0;
            mem_pos    = '0;
            next_state = IDLE;
        end
    end
`else
    assign in_idle = 1'b1;
    assign stall   = 1'b0;

    always_comb begin
        mem_pos  = word_pos;
        mem_data = req_wdata;
        mem_wr   = req_valid & aligned & req_wr;
        if (rst) begin
            mem_pos = '0;
            mem_wr  = 1'b0;
        end
    end
`endif

    assign load_go   = in_idle & req_valid & aligned & ~req_wr;
    assign reject_go = in_idle & req_valid & ~aligned;

    // Registered load result and reject pulse toward MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_valid <= 1'b0;
            ld_data  <= '0;
            misalign <= 1'b0;
        end else begin
            ld_valid <= load_go;
            misalign <= reject_go;
            if (load_go) ld_data <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed bench for mem_access_ctrl against a word-array reference model.
// Follows MEM_SUBWORD_EN the same way as the design.
module tb_mem_access_ctrl;
`ifdef MEM_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign;
    logic [31:0] mem_pos;
    logic [31:0] mem_data;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .ld_valid(ld_valid),
        .ld_data(ld_data), .misalign(misalign), .mem_pos(mem_pos),
        .mem_data(mem_data), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-only data memory seen by the DUT
    assign mem_rdata = mem[mem_pos[11:2]];
    always @(posedge clk) if (mem_wr) mem[mem_pos[11:2]] <= mem_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_aligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd2) return (addr % 4) == 0;
        if (!SUBWORD) return 1'b0;
        if (size == 2'd1) return (addr % 2) == 0;
        return size == 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] size,
                                           input bit sgn, input logic [31:0] addr);
        int unsigned off;
        logic [31:0] v;
        off = addr % 4;
        if (size == 2'd0) begin
            v = (word >> ((3 - off) * 8)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (word >> ((2 - off) * 8)) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] word, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned off;
        int unsigned sh;
        logic [31:0] mask;
        if (size == 2'd2) return wdata;
        off  = addr % 4;
        mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
        sh   = (size == 2'd0) ? (3 - off) * 8 : (2 - off) * 8;
        return (word & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    task automatic drive(input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // One request from issue to completion, including the merge cycle of sub-word stores
    task automatic do_op(input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bit ok;
        bit sub_st;
        int idx;
        logic [31:0] nw;
        ok     = m_aligned(size, addr);
        sub_st = ok && wr && (size != 2'd2);
        idx    = int'(addr[11:2]);
        nw     = m_store(ref_mem[idx], size, addr, wdata);
        drive(wr, size, sgn, addr, wdata);
        @(negedge clk);
        check_eq("stall", 32'(stall), 32'(sub_st));
        check_eq("mem_wr", 32'(mem_wr), 32'(ok && wr && size == 2'd2));
        check_eq("mem_pos", mem_pos, {addr[31:2], 2'b00});
        if (ok && wr && size == 2'd2) check_eq("mem_data_word", mem_data, wdata);
        @(posedge clk); #1;
        check_eq("ld_valid", 32'(ld_valid), 32'(ok && !wr));
        check_eq("misalign", 32'(misalign), 32'(!ok));
        if (ok && !wr) check_eq("ld_data", ld_data, m_load(ref_mem[idx], size, sgn, addr));
        if (sub_st) begin
            @(negedge clk);
            check_eq("merge_wr", 32'(mem_wr), 32'd1);
            check_eq("merge_stall", 32'(stall), 32'd0);
            check_eq("merge_pos", mem_pos, {addr[31:2], 2'b00});
            check_eq("merge_data", mem_data, nw);
            @(posedge clk); #1;
            check_eq("merge_ld_valid", 32'(ld_valid), 32'd0);
            check_eq("merge_misalign", 32'(misalign), 32'd0);
        end
        if (ok && wr) ref_mem[idx] = nw;
        check_eq("mem_word", mem[idx], ref_mem[idx]);
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 32'($urandom_range(0, 63));
        @(negedge clk);
        check_eq("idle_stall", 32'(stall), 32'd0);
        check_eq("idle_wr", 32'(mem_wr), 32'd0);
        @(posedge clk); #1;
        check_eq("idle_ld_valid", 32'(ld_valid), 32'd0);
        check_eq("idle_misalign", 32'(misalign), 32'd0);
    endtask

    // Byte store interrupted by reset in its merge cycle: write must be dropped
    task automatic reset_in_merge(input logic [31:0] addr, input logic [31:0] wdata);
        int idx;
        idx = int'(addr[11:2]);
        if (!m_aligned(2'd0, addr)) begin
            do_op(1'b1, 2'd0, 1'b0, addr, wdata);
            return;
        end
        drive(1'b1, 2'd0, 1'b0, addr, wdata);
        @(negedge clk);
        check_eq("rm_stall", 32'(stall), 32'd1);
        check_eq("rm_wr_first", 32'(mem_wr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rm_wr_reset", 32'(mem_wr), 32'd0);
        check_eq("rm_stall_reset", 32'(stall), 32'd0);
        check_eq("rm_pos_reset", mem_pos, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        check_eq("rm_word", mem[idx], ref_mem[idx]);
        check_eq("rm_ld_valid", 32'(ld_valid), 32'd0);
        check_eq("rm_ld_data", ld_data, 32'd0);
        check_eq("rm_misalign", 32'(misalign), 32'd0);
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_F00D);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_pos", mem_pos, 32'd0);
        check_eq("rst_ld_valid", 32'(ld_valid), 32'd0);
        check_eq("rst_ld_data", ld_data, 32'd0);
        check_eq("rst_misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;

        for (int i = 0; i < 16; i++) do_op(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_eq("lw_deadbeef", ld_data, 32'hDEAD_BEEF);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_F344);
        do_op(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
        do_op(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);

        do_op(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_5555);
        do_op(1'b1, 2'd3, 1'b0, 32'h10, 32'h7777_7777);
        do_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
        do_op(1'b0, 2'd3, 1'b1, 32'h10, 32'h0);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        reset_in_merge(32'h10, 32'h0000_00CC);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_eq("word_after_reset", ld_data, 32'h1122_3344);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            do_op(1'($urandom), 2'($urandom), 1'($urandom),
                  32'($urandom_range(0, 63)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
